// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sensor reader: FSM states, frame layout
// constants and the degree clamp helper.
package temp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CONVERT,
        UPDATE
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int RAW_MSB    = 15;
    localparam int RAW_LSB    = 5;
    localparam int DEG_LSB    = 7;
    localparam int TEMP_MAX   = 99;

    localparam int RAW_BITS   = RAW_MSB - RAW_LSB + 1;
    // Two guard bits so a sum of four readings fits before the divide.
    localparam int DEG_W      = RAW_BITS + 2;

    typedef struct packed {
        logic [6:0] value;
        logic       neg;
        logic       ovr;
    } clamp_t;

    function automatic clamp_t clamp_deg(input logic signed [DEG_W-1:0] deg);
        clamp_t r;
        r.value = deg[6:0];
        r.neg   = 1'b0;
        r.ovr   = 1'b0;
        if (int'(deg) < 0) begin
            r.value = 7'd0;
            r.neg   = 1'b1;
        end else if (int'(deg) > TEMP_MAX) begin
            r.value = 7'(TEMP_MAX);
            r.ovr   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/temp_sensor_reader_bin2bcd.sv
// Sequential double-dabble: converts a 7-bit binary value into tens/units BCD
// digits, one shift per cycle, done pulses 7 cycles after start.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [14:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  t_adj, u_adj;
    logic [14:0] adj;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        t_adj  = (sr_q[14:11] >= 4'd5) ? sr_q[14:11] + 4'd3 : sr_q[14:11];
        u_adj  = (sr_q[10:7]  >= 4'd5) ? sr_q[10:7]  + 4'd3 : sr_q[10:7];
        adj    = {t_adj, u_adj, sr_q[6:0]};
        if (start) begin
            sr_d   = {8'd0, bin};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = adj << 1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done  = done_q;
    assign tens  = sr_q[14:11];
    assign units = sr_q[10:7];

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI mode-0 reader for the temperature sensor, producing clamped BCD degrees.
// Define TEMP_AVG_EN to average the last four readings before conversion.
module temp_sensor_reader
    import temp_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    input  logic       spi_miso,
    output logic [3:0] TEMP_t,
    output logic [3:0] TEMP_u,
    output logic       temp_neg,
    output logic       temp_ovr,
    output logic       temp_valid
);

    localparam int TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]         BIT_LAST   = 4'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [3:0]              bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    started_q, started_d;
    logic [3:0]              temp_t_q, temp_t_d;
    logic [3:0]              temp_u_q, temp_u_d;
    logic                    neg_q, neg_d;
    logic                    ovr_q, ovr_d;
    logic                    valid_q, valid_d;

    logic                    bcd_start, bcd_done;
    logic [3:0]              bcd_tens, bcd_units;
    logic signed [RAW_BITS-1:0] reading;
    logic signed [DEG_W-1:0]    deg;
    clamp_t                     clamp_r;

    assign reading = shift_q[RAW_MSB:RAW_LSB];

`ifdef TEMP_AVG_EN
    logic signed [RAW_BITS-1:0] buf_q [4];
    logic signed [RAW_BITS-1:0] buf_d [4];
    logic signed [DEG_W-1:0]    buf_ext [4];
    logic signed [DEG_W-1:0]    buf_sum, buf_avg;
    logic [1:0]                 wr_ptr_q, wr_ptr_d;
    logic                       filled_q, filled_d;
    logic                       frame_done;

    assign frame_done = (state_q == CS_HOLD) && (div_q == DIV_LAST);

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_ext
        assign buf_ext[gi] = {{(DEG_W-RAW_BITS){buf_q[gi][RAW_BITS-1]}}, buf_q[gi]};
    end

    assign buf_sum = buf_ext[0] + buf_ext[1] + buf_ext[2] + buf_ext[3];
    assign buf_avg = buf_sum >>> 2;
    assign deg     = buf_avg >>> (DEG_LSB - RAW_LSB);

    always_comb begin
        for (int i = 0; i < 4; i++) buf_d[i] = buf_q[i];
        wr_ptr_d = wr_ptr_q;
        filled_d = filled_q;
        if (frame_done) begin
            // First frame after reset seeds every slot so the average starts at that reading.
            if (!filled_q) begin
                for (int i = 0; i < 4; i++) buf_d[i] = reading;
                filled_d = 1'b1;
                wr_ptr_d = 2'd0;
            end else begin
                buf_d[wr_ptr_q] = reading;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
            wr_ptr_q <= '0;
            filled_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
            wr_ptr_q <= wr_ptr_d;
            filled_q <= filled_d;
        end
    end
`else
    assign deg = $signed({{(DEG_W-RAW_BITS){reading[RAW_BITS-1]}}, reading})
                 >>> (DEG_LSB - RAW_LSB);
`endif

    assign clamp_r = clamp_deg(deg);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        shift_d   = shift_q;
        started_d = started_q;
        temp_t_d  = temp_t_q;
        temp_u_d  = temp_u_q;
        neg_d     = neg_q;
        ovr_d     = ovr_q;
        valid_d   = 1'b0;
        bcd_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (timer_q == TIMER_LAST) begin
                    cs_n_d  = 1'b0;
                    timer_d = '0;
                    div_d   = '0;
                    state_d = CS_SETUP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[FRAME_BITS-2:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) state_d = CS_HOLD;
                        else                   bit_d   = bit_q + 4'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    started_d = 1'b0;
                    state_d   = CONVERT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            CONVERT: begin
                if (!started_q) begin
                    bcd_start = 1'b1;
                    started_d = 1'b1;
                end else if (bcd_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // Digits and flags commit together so the display never sees a mix.
                temp_t_d = bcd_tens;
                temp_u_d = bcd_units;
                neg_d    = clamp_r.neg;
                ovr_d    = clamp_r.ovr;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= TIMER_LAST;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            shift_q   <= '0;
            started_q <= 1'b0;
            temp_t_q  <= '0;
            temp_u_q  <= '0;
            neg_q     <= 1'b0;
            ovr_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            shift_q   <= shift_d;
            started_q <= started_d;
            temp_t_q  <= temp_t_d;
            temp_u_q  <= temp_u_d;
            neg_q     <= neg_d;
            ovr_q     <= ovr_d;
            valid_q   <= valid_d;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .bin   (clamp_r.value),
        .done  (bcd_done),
        .tens  (bcd_tens),
        .units (bcd_units)
    );

    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign TEMP_t     = temp_t_q;
    assign TEMP_u     = temp_u_q;
    assign temp_neg   = neg_q;
    assign temp_ovr   = ovr_q;
    assign temp_valid = valid_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: SPI sensor model, frame table with a scoreboard,
// plus reset-state, mid-frame reset and frame-spacing sequences.
`timescale 1ns/1ps
module tb_temp_sensor_reader;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk, spi_cs_n;
    logic       spi_miso = 1'b0;
    logic [3:0] TEMP_t, TEMP_u;
    logic       temp_neg, temp_ovr, temp_valid;

    temp_sensor_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .TEMP_t     (TEMP_t),
        .TEMP_u     (TEMP_u),
        .temp_neg   (temp_neg),
        .temp_ovr   (temp_ovr),
        .temp_valid (temp_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] u;
        logic       neg;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [15:0] frame;
        exp_t        exp;
    } vec_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] next_frame = '0;
    exp_t        next_exp = '0;
    logic [15:0] cur_frame = '0;
    int          bit_idx = 0;
    bit          serving = 0;
    int          sclk_rises = 0;
    int          rise_mark = 0;
    int          valid_cnt = 0;
    int          cyc = 0;
    int          last_valid_cyc = 0;
    bit          gap_armed = 0;
    logic        prev_valid = 1'b0;
    logic        cs_prev = 1'b1;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge spi_sclk) sclk_rises <= sclk_rises + 1;

    // Sensor: presents the MSB when selected, then the next bit on each SCLK fall.
    always @(negedge spi_sclk or negedge spi_cs_n or posedge spi_cs_n) begin
        if (spi_cs_n === 1'b1) begin
            serving = 0;
        end else if (rst_n === 1'b1 && spi_cs_n === 1'b0) begin
            if (!serving) begin
                serving   = 1;
                cur_frame = next_frame;
                bit_idx   = 15;
                spi_miso  = cur_frame[15];
                rise_mark = sclk_rises;
                exp_q.push_back(next_exp);
            end else if (bit_idx > 0) begin
                bit_idx  = bit_idx - 1;
                spi_miso = cur_frame[bit_idx];
            end
        end
    end

    // Monitor: scoreboard pop on each valid, pulse width, SCLK count and frame spacing.
    always @(negedge clk) begin
        if (prev_valid) begin
            checks++;
            if (temp_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_width: temp_valid=%b required 0 on cycle after pulse", temp_valid);
            end
        end
        if (!rst_n) begin
            gap_armed = 0;
        end else begin
            if (cs_prev === 1'b1 && spi_cs_n === 1'b0 && gap_armed) begin
                checks++;
                if (cyc - last_valid_cyc != SAMPLE_PERIOD) begin
                    errors++;
                    $display("FAIL frame_gap: cs_n fell %0d cycles after valid, required %0d",
                             cyc - last_valid_cyc, SAMPLE_PERIOD);
                end
                gap_armed = 0;
            end
            if (temp_valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                gap_armed = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: t=%0d u=%0d with no frame pending", TEMP_t, TEMP_u);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({TEMP_t, TEMP_u, temp_neg, temp_ovr} !== mon_e) begin
                        errors++;
                        $display("FAIL digits: got t=%0d u=%0d neg=%b ovr=%b required t=%0d u=%0d neg=%b ovr=%b",
                                 TEMP_t, TEMP_u, temp_neg, temp_ovr, mon_e.t, mon_e.u, mon_e.neg, mon_e.ovr);
                    end else begin
                        $display("valid #%0d: frame %h t=%0d u=%0d neg=%b ovr=%b ok",
                                 valid_cnt, cur_frame, TEMP_t, TEMP_u, temp_neg, temp_ovr);
                    end
                end
                checks++;
                if (sclk_rises - rise_mark != 16) begin
                    errors++;
                    $display("FAIL sclk_count: %0d rising edges in frame, required 16", sclk_rises - rise_mark);
                end
            end
        end
        prev_valid = temp_valid;
        cs_prev    = spi_cs_n;
    end

    function automatic vec_t mk(input logic [15:0] f, input int t, input int u, input bit n, input bit o);
        vec_t v;
        v.frame   = f;
        v.exp.t   = 4'(t);
        v.exp.u   = 4'(u);
        v.exp.neg = n;
        v.exp.ovr = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_valid(input int target, input string name);
        int n = 0;
        while (valid_cnt < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (valid_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: no temp_valid within 1000 cycles (got %0d pulses, required %0d)",
                     name, valid_cnt, target);
        end
    endtask

    task automatic set_next(input vec_t v);
        next_frame = v.frame;
        next_exp   = v.exp;
    endtask

    initial begin
        vec_t tbl[$];
        int   n;
        int   vc;

`ifdef TEMP_AVG_EN
        tbl.push_back(mk(16'h0C80, 2, 5, 0, 0));
        tbl.push_back(mk(16'h0C80, 2, 5, 0, 0));
        tbl.push_back(mk(16'h0C80, 2, 5, 0, 0));
        tbl.push_back(mk(16'h0E80, 2, 6, 0, 0));
`else
        tbl.push_back(mk(16'h0C80, 2, 5, 0, 0));
        tbl.push_back(mk(16'h3200, 9, 9, 0, 1));
        tbl.push_back(mk(16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(16'hFF80, 0, 0, 1, 0));
        tbl.push_back(mk(16'h18E0, 4, 9, 0, 0));
        tbl.push_back(mk(16'h0C60, 2, 4, 0, 0));
        tbl.push_back(mk(16'h3180, 9, 9, 0, 0));
        tbl.push_back(mk(16'h0080, 0, 1, 0, 0));
        tbl.push_back(mk(16'h8000, 0, 0, 1, 0));
        tbl.push_back(mk(16'h0040, 0, 0, 0, 0));
        tbl.push_back(mk(16'hFFE0, 0, 0, 1, 0));
        tbl.push_back(mk(16'h7FE0, 9, 9, 0, 1));
`endif

        // Reset state
        rst_n = 1'b0;
        set_next(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(spi_sclk), 0);
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_temp_t", 32'(TEMP_t), 0);
        chk("rst_temp_u", 32'(TEMP_u), 0);
        chk("rst_flags", 32'({temp_neg, temp_ovr}), 0);
        chk("rst_valid", 32'(temp_valid), 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("cs_first_cycle", 32'(spi_cs_n), 0);

        // Table of frames, one frame per sample period
        for (int i = 0; i < tbl.size(); i++) begin
            wait_valid(i + 1, "table_frame");
            if (i + 1 < tbl.size()) set_next(tbl[i + 1]);
        end

        // Reset asserted while the 8th SCLK is high
        set_next(mk(16'h0C80, 2, 5, 0, 0));
        n = 0;
        while (!(spi_cs_n === 1'b0 && (sclk_rises - rise_mark) >= 8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL midframe_wait: 8th SCLK not reached, rises=%0d", sclk_rises - rise_mark);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(spi_cs_n), 1);
        chk("midrst_sclk", 32'(spi_sclk), 0);
        chk("midrst_digits", 32'({TEMP_t, TEMP_u}), 0);
        chk("midrst_flags", 32'({temp_neg, temp_ovr, temp_valid}), 0);
        exp_q.delete();
        set_next(mk(16'h18E0, 4, 9, 0, 0));
        repeat (3) @(negedge clk);
        vc = valid_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cs_first_cycle_after_midrst", 32'(spi_cs_n), 0);
        wait_valid(vc + 1, "post_reset_frame");

        // One more spacing measurement after the recovered frame
        set_next(mk(16'h0C80, 2, 5, 0, 0));
        wait_valid(vc + 2, "spacing_frame");
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
